// File: rtl/seg_scroll_seq_if.sv
// Control and display bundle for seg_scroll_seq: switch/button inputs, sequence write port, 7-seg outputs.
// master drives the controls and sequence writes; slave is the scroller.
interface seg_scroll_seq_if #(
  parameter int ADDR_W     = 4,
  parameter int NUM_DIGITS = 4
);
  logic [1:0]              sw;
  logic                    dir;
  logic                    hold;
  logic [ADDR_W-1:0]       len;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [3:0]              wr_data;
  logic [7*NUM_DIGITS-1:0] seg;
  logic [ADDR_W-1:0]       ptr;
  logic                    tick;

  modport master (
    output sw, dir, hold, len, wr_en, wr_addr, wr_data,
    input  seg, ptr, tick
  );

  modport slave (
    input  sw, dir, hold, len, wr_en, wr_addr, wr_data,
    output seg, ptr, tick
  );
endinterface

// File: rtl/seg_scroll_seq.sv
// Scrolls a NUM_DIGITS window over a writable digit sequence at one of three prescaled rates; BLINK_EN blinks on hold.
// Latency: seg registered, 1 cycle after ptr/mem change; tick is combinational from the prescaler.
// Backpressure: none; writes are accepted every cycle, out-of-range addresses are dropped.
module seg_scroll_seq #(
  parameter int DIV_BITS   = 26,
  parameter int NUM_DIGITS = 4,
  parameter int MAX_LEN    = 10,
  parameter int ADDR_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  seg_scroll_seq_if.slave  bus
);
  localparam int LW = ADDR_W + 1;
  localparam int IW = ADDR_W + $clog2(NUM_DIGITS) + 1;

  logic [DIV_BITS-1:0]     p;
  logic [ADDR_W-1:0]       ptr_q;
  logic [ADDR_W-1:0]       ptr_nxt;
  logic [3:0]              mem [MAX_LEN];
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic [7*NUM_DIGITS-1:0] seg_nxt;
  logic [LW-1:0]           eff_len;
  logic [IW-1:0]           idx  [NUM_DIGITS];
  logic [3:0]              code [NUM_DIGITS];
  logic                    tick;
  logic                    blank;

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      4'd15:   dec = 7'b0111111;
      default: dec = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    case (bus.sw)
      2'b00:   tick = &p;
      2'b10:   tick = &p[DIV_BITS-2:0];
      default: tick = &p[DIV_BITS-3:0];
    endcase
  end

  assign eff_len = (bus.len == '0 || LW'(bus.len) > LW'(MAX_LEN)) ? LW'(MAX_LEN) : LW'(bus.len);

`ifdef BLINK_EN
  assign blank = bus.hold & p[DIV_BITS-1];
`else
  assign blank = 1'b0;
`endif

  // ptr may sit beyond a freshly shrunk length; both directions fold it back in range.
  always_comb begin
    ptr_nxt = ptr_q;
    if (tick && !bus.hold) begin
      if (bus.dir)
        ptr_nxt = (LW'(ptr_q) >= eff_len - LW'(1)) ? '0 : ptr_q + ADDR_W'(1);
      else
        ptr_nxt = (ptr_q == '0 || LW'(ptr_q) >= eff_len) ? ADDR_W'(eff_len - LW'(1))
                                                         : ptr_q - ADDR_W'(1);
    end
  end

  always_comb begin
    seg_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      idx[k]  = (IW'(ptr_q) + IW'(k)) % IW'(eff_len);
      code[k] = 4'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (idx[k] == IW'(i)) code[k] = mem[i];
      end
      if (!blank) seg_nxt[7*k +: 7] = dec(code[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p     <= '0;
      ptr_q <= '0;
      seg_q <= '1;
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= 4'(i % 10);
    end else begin
      p     <= p + DIV_BITS'(1);
      ptr_q <= ptr_nxt;
      seg_q <= seg_nxt;
      if (bus.wr_en && LW'(bus.wr_addr) < LW'(MAX_LEN)) mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.ptr  = ptr_q;
  assign bus.tick = tick;
endmodule
